// File: rtl/sevenseg_scanner_if.sv
// ---------------------------------------------------------------------------
// sevenseg_scanner_if
//
// Carries the display-update handshake from the CPU debug path into the
// seven-segment scanner.
//
// Signals:
//   upd_valid  master -> slave  update request
//   upd_ready  slave  -> master high when an update can be accepted
//   upd_sel    master -> slave  display selector (dispsel_t encoding, 3 bits)
//   upd_value  master -> slave  16-bit value to display
//
// Modports:
//   master  the update producer (CPU side / testbench driver)
//   slave   the scanner
// ---------------------------------------------------------------------------
interface sevenseg_scanner_if;
    logic        upd_valid;
    logic        upd_ready;
    logic [2:0]  upd_sel;
    logic [15:0] upd_value;

    modport master (
        output upd_valid,
        output upd_sel,
        output upd_value,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_sel,
        input  upd_value,
        output upd_ready
    );
endinterface

// File: rtl/sevenseg_scanner.sv
// ---------------------------------------------------------------------------
// sevenseg_scanner
//
// Multiplexed four-digit seven-segment display driver for the CPU debug
// display path. A (selector, value) update is accepted over a valid/ready
// handshake into a single pending slot and copied into the displayed
// registers only at a frame boundary, so a frame never mixes old and new
// digits. Digits are scanned with a prescaled counter; the first cycle of
// every digit slot is dark (all anodes off) to suppress ghosting.
//
// Parameters:
//   PRESCALE   clock cycles per digit slot (minimum 2)
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   upd         sevenseg_scanner_if.slave: upd_valid/upd_ready/upd_sel/upd_value
//   seg_n[6:0]  segments {g,f,e,d,c,b,a}, active-low, registered
//   dp_n        decimal point, active-low, registered; lit on digit 0 while
//               an update is queued
//   an_n[3:0]   digit anodes, active-low, registered; bit 0 = rightmost digit
//   frame_done  one-cycle pulse in the last cycle of each frame
//
// Build option:
//   SEG_LEADING_ZERO_BLANK_EN  when defined, leading zero nibbles on digits
//                              3..1 are blanked in the 16-bit modes
//                              (CC, PC, ADDR). Digit 0 is always shown.
// ---------------------------------------------------------------------------
module sevenseg_scanner #(
    parameter int PRESCALE = 50000
) (
    input  logic                clk,
    input  logic                reset,
    sevenseg_scanner_if.slave   upd,
    output logic [6:0]          seg_n,
    output logic                dp_n,
    output logic [3:0]          an_n,
    output logic                frame_done
);

    typedef enum logic [2:0] {
        DISP_CC    = 3'd0,
        DISP_PC    = 3'd1,
        DISP_ADDR  = 3'd2,
        DISP_INSTR = 3'd3,
        DISP_X     = 3'd4,
        DISP_OP    = 3'd5,
        DISP_STATE = 3'd6,
        DISP_UNDEF = 3'd7
    } dispsel_t;

    localparam int              PW        = $clog2(PRESCALE);
    localparam logic [PW-1:0]   PCNT_LAST = PW'(PRESCALE - 1);

    localparam logic [6:0] G_BLANK = 7'h7F;
    localparam logic [6:0] G_DASH  = 7'h3F;
    localparam logic [6:0] G_I     = 7'h79;
    localparam logic [6:0] G_X     = 7'h09;
    localparam logic [6:0] G_O     = 7'h23;
    localparam logic [6:0] G_S     = 7'h12;

    if (PRESCALE < 2) begin : g_prescale_check
        $error("sevenseg_scanner: PRESCALE must be at least 2");
    end

    logic [PW-1:0] pcnt;
    logic [1:0]    digit;
    dispsel_t      active_sel;
    logic [15:0]   active_val;
    dispsel_t      pend_sel;
    logic [15:0]   pend_val;
    logic          pend_flag;

    logic          pcnt_last;
    logic          xfer;
    logic [3:0]    nibble;
    logic [6:0]    tag;
    logic          lz_blank;
    logic [6:0]    glyph;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        hex_glyph = G_BLANK;
        case (n)
            4'h0: hex_glyph = 7'h40;
            4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;
            4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;
            4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;
            4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;
            4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;
            4'hF: hex_glyph = 7'h0E;
        endcase
    endfunction

    assign pcnt_last     = (pcnt == PCNT_LAST);
    assign frame_done    = pcnt_last && (digit == 2'd3);
    assign upd.upd_ready = !pend_flag;
    assign xfer          = upd.upd_valid && !pend_flag;

    // Refresh counters: pcnt walks through one digit slot, digit advances
    // on the last cycle of each slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt  <= '0;
            digit <= 2'd0;
        end else if (pcnt_last) begin
            pcnt  <= '0;
            digit <= digit + 2'd1;
        end else begin
            pcnt  <= pcnt + 1'b1;
        end
    end

    // Single-entry update queue. While the slot is full ready is low, so a
    // transfer can never coincide with the boundary that drains the slot;
    // a transfer during a boundary with the slot empty therefore waits for
    // the following boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_sel <= DISP_CC;
            active_val <= 16'h0000;
            pend_sel   <= DISP_CC;
            pend_val   <= 16'h0000;
            pend_flag  <= 1'b0;
        end else if (frame_done && pend_flag) begin
            active_sel <= pend_sel;
            active_val <= pend_val;
            pend_flag  <= 1'b0;
        end else if (xfer) begin
            pend_sel   <= dispsel_t'(upd.upd_sel);
            pend_val   <= upd.upd_value;
            pend_flag  <= 1'b1;
        end
    end

    // Glyph for the digit currently being scanned.
    always_comb begin
        nibble   = 4'h0;
        tag      = G_I;
        lz_blank = 1'b0;
        glyph    = G_DASH;

        case (digit)
            2'd0: nibble = active_val[3:0];
            2'd1: nibble = active_val[7:4];
            2'd2: nibble = active_val[11:8];
            2'd3: nibble = active_val[15:12];
        endcase

        case (active_sel)
            DISP_X:     tag = G_X;
            DISP_OP:    tag = G_O;
            DISP_STATE: tag = G_S;
            default:    tag = G_I;
        endcase

`ifdef SEG_LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and every digit to its left are zero.
        case (digit)
            2'd3:    lz_blank = (active_val[15:12] == 4'h0);
            2'd2:    lz_blank = (active_val[15:8]  == 8'h00);
            2'd1:    lz_blank = (active_val[15:4]  == 12'h000);
            default: lz_blank = 1'b0;
        endcase
`else
        lz_blank = 1'b0;
`endif

        case (active_sel)
            DISP_CC, DISP_PC, DISP_ADDR: begin
                glyph = lz_blank ? G_BLANK : hex_glyph(nibble);
            end
            DISP_INSTR, DISP_X, DISP_OP, DISP_STATE: begin
                if (digit == 2'd3) begin
                    glyph = tag;
                end else if (digit == 2'd2) begin
                    glyph = G_BLANK;
                end else begin
                    glyph = hex_glyph(nibble);
                end
            end
            default: glyph = G_DASH;
        endcase
    end

    // Registered pin drivers; the first cycle of each slot is forced dark.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_n <= G_BLANK;
            an_n  <= 4'hF;
            dp_n  <= 1'b1;
        end else if (pcnt == '0) begin
            seg_n <= G_BLANK;
            an_n  <= 4'hF;
            dp_n  <= 1'b1;
        end else begin
            seg_n <= glyph;
            an_n  <= ~(4'b0001 << digit);
            dp_n  <= !((digit == 2'd0) && pend_flag);
        end
    end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// ---------------------------------------------------------------------------
// tb_sevenseg_scanner
//
// Self-checking bench for sevenseg_scanner with PRESCALE=4 (16-cycle frame).
// The driver pushes the expected four-glyph frame for every accepted update
// into a queue; the monitor runs on the falling edge, predicts the scan
// position from the cycle count since reset, pops the queue at each frame
// boundary and compares seg_n/an_n/dp_n/frame_done/upd_ready every cycle.
// ---------------------------------------------------------------------------
module tb_sevenseg_scanner;

    localparam int P     = 4;
    localparam int FRAME = 4 * P;
    localparam int LIMIT = 10 * FRAME;

    localparam logic [2:0] SEL_CC    = 3'd0;
    localparam logic [2:0] SEL_PC    = 3'd1;
    localparam logic [2:0] SEL_ADDR  = 3'd2;
    localparam logic [2:0] SEL_INSTR = 3'd3;
    localparam logic [2:0] SEL_X     = 3'd4;
    localparam logic [2:0] SEL_OP    = 3'd5;
    localparam logic [2:0] SEL_STATE = 3'd6;
    localparam logic [2:0] SEL_UNDEF = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    sevenseg_scanner_if upd_if();

    sevenseg_scanner #(.PRESCALE(P)) dut (
        .clk        (clk),
        .reset      (reset),
        .upd        (upd_if),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int          compared = 0;
    int          failed   = 0;
    int          stateIdx = 0;
    logic [27:0] expQ[$];
    logic [27:0] curFrame;
    bit          expValid = 1'b0;
    logic [6:0]  expSeg;
    logic [3:0]  expAn;
    logic        expDp;
    int          monK;
    int          monSlot;
    int          monDigit;
    bit          monPend;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] hexOf(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Glyph of one digit position, straight from the display rules.
    function automatic logic [6:0] glyphOf(input logic [2:0] sel, input logic [15:0] val, input int d);
        logic [3:0] nib;
        nib = 4'((val >> (4 * d)) & 16'hF);
        if (sel <= SEL_ADDR) begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (d > 0 && (val >> (4 * d)) == 16'h0) return 7'h7F;
`endif
            return hexOf(nib);
        end else if (sel <= SEL_STATE) begin
            if (d == 3) begin
                case (sel)
                    SEL_INSTR: return 7'h79;
                    SEL_X:     return 7'h09;
                    SEL_OP:    return 7'h23;
                    default:   return 7'h12;
                endcase
            end
            if (d == 2) return 7'h7F;
            return hexOf(nib);
        end
        return 7'h3F;
    endfunction

    function automatic logic [27:0] frameOf(input logic [2:0] sel, input logic [15:0] val);
        logic [27:0] f;
        for (int d = 0; d < 4; d++) f[7*d +: 7] = glyphOf(sel, val, d);
        return f;
    endfunction

    // Cycle index since reset release: index 0 is the first cycle after the
    // reset edge, matching pcnt=0, digit=0.
    always @(posedge clk) begin
        if (reset) stateIdx <= 0;
        else       stateIdx <= stateIdx + 1;
    end

    // Monitor/scoreboard: check last cycle's prediction, then predict the
    // outputs of the next cycle from the scan position and displayed frame.
    always @(negedge clk) begin
        if (reset) begin
            expQ.delete();
            curFrame = frameOf(SEL_CC, 16'h0000);
            expValid = 1'b0;
        end else begin
            monK    = stateIdx;
            monPend = (expQ.size() != 0);
            if (monK == 0) begin
                checkOutput("reset_seg_n", 32'(seg_n), 32'h7F);
                checkOutput("reset_an_n",  32'(an_n),  32'hF);
                checkOutput("reset_dp_n",  32'(dp_n),  32'h1);
            end else if (expValid) begin
                checkOutput("seg_n", 32'(seg_n), 32'(expSeg));
                checkOutput("an_n",  32'(an_n),  32'(expAn));
                checkOutput("dp_n",  32'(dp_n),  32'(expDp));
            end
            checkOutput("frame_done", 32'(frame_done), 32'((monK % FRAME) == FRAME - 1));
            checkOutput("upd_ready",  32'(upd_if.upd_ready), 32'(!monPend));

            monSlot  = monK % P;
            monDigit = (monK / P) % 4;
            if (monSlot == 0) begin
                expAn  = 4'hF;
                expSeg = 7'h7F;
                expDp  = 1'b1;
            end else begin
                expAn  = ~(4'b0001 << monDigit);
                expSeg = curFrame[7*monDigit +: 7];
                expDp  = !(monDigit == 0 && monPend);
            end
            expValid = 1'b1;

            if ((monK % FRAME) == FRAME - 1 && monPend) curFrame = expQ.pop_front();
        end
    end

    // Present one update starting at a falling edge; returns at the falling
    // edge after the transfer. With hold set, valid stays high so the next
    // call continues the request back-to-back.
    task automatic applyStimulus(input logic [2:0] sel, input logic [15:0] val, input bit hold);
        int waited = 0;
        upd_if.upd_valid = 1'b1;
        upd_if.upd_sel   = sel;
        upd_if.upd_value = val;
        while (!upd_if.upd_ready && waited < LIMIT) begin
            @(negedge clk);
            waited++;
        end
        if (!upd_if.upd_ready) begin
            checkOutput("xfer_timeout", 32'(upd_if.upd_ready), 32'h1);
            upd_if.upd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        expQ.push_back(frameOf(sel, val));
        #1;
        if (!hold) upd_if.upd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitFrames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    task automatic waitBoundary();
        int n = 0;
        while (!frame_done && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!frame_done) checkOutput("boundary_timeout", 32'(frame_done), 32'h1);
    endtask

    initial begin
        bit       prevHold;
        bit       hold;
        int       gap;
        reset            = 1'b1;
        upd_if.upd_valid = 1'b0;
        upd_if.upd_sel   = 3'd0;
        upd_if.upd_value = 16'h0000;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] reset scan check");
        waitFrames(3);

        $display("[TB] 16-bit update");
        applyStimulus(SEL_PC, 16'h1A2F, 1'b0);
        checkOutput("ready_after_xfer", 32'(upd_if.upd_ready), 32'h0);
        waitFrames(3);
        applyStimulus(SEL_ADDR, 16'h002F, 1'b0);
        waitFrames(3);

        $display("[TB] 8-bit and undefined selector updates");
        applyStimulus(SEL_X, 16'h00C3, 1'b0);
        waitFrames(3);
        applyStimulus(SEL_UNDEF, 16'h1234, 1'b0);
        waitFrames(3);

        $display("[TB] back-pressure");
        applyStimulus(SEL_ADDR, 16'hBEEF, 1'b1);
        applyStimulus(SEL_CC, 16'h0042, 1'b0);
        waitFrames(3);

        $display("[TB] boundary collision");
        waitBoundary();
        applyStimulus(SEL_OP, 16'h005A, 1'b0);
        waitFrames(3);

        $display("[TB] reset with update pending");
        waitBoundary();
        repeat (2) @(negedge clk);
        applyStimulus(SEL_STATE, 16'h00EE, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(upd_if.upd_ready), 32'h1);
        waitFrames(3);

        $display("[TB] randomized updates");
        prevHold = 1'b0;
        for (int i = 0; i < 24; i++) begin
            gap = $urandom_range(0, 3 * FRAME);
            if (!prevHold) repeat (gap) @(negedge clk);
            hold = (i < 23) && ($urandom_range(0, 3) == 0);
            applyStimulus(3'($urandom_range(0, 7)), 16'($urandom), hold);
            prevHold = hold;
        end
        waitFrames(3);
        checkOutput("queue_drained", 32'(expQ.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
